// File: rtl/iq_read.sv
// iq_read: pops byte stream, assembles little-endian 16-bit I/Q pairs and
// pushes them sign-extended and shifted left by BITS into paired I/Q FIFOs.
module iq_read #(
    parameter int DATA_WIDTH       = 32,
    parameter int BITS             = 10,
    parameter int BYTES_PER_SAMPLE = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] i_out,
    output logic [DATA_WIDTH-1:0] q_out,
    output logic                  i_wr_en,
    output logic                  q_wr_en,
    input  logic                  i_full,
    input  logic                  q_full
);
    typedef enum logic {S_READ, S_WRITE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_byte_cnt;
    logic [3:0][7:0] r_b;
    logic [15:0]     w_i16;
    logic [15:0]     w_q16;
    logic            w_rd;
    logic            w_wr;

    assign w_i16 = {r_b[1], r_b[0]};
    assign w_q16 = {r_b[3], r_b[2]};
    assign i_out = {{(DATA_WIDTH-16){w_i16[15]}}, w_i16} << BITS;
    assign q_out = {{(DATA_WIDTH-16){w_q16[15]}}, w_q16} << BITS;
    assign in_rd_en = w_rd;
    assign i_wr_en  = w_wr;
    assign q_wr_en  = w_wr;

    // Reset gates the pop strobe so nothing is consumed while held in reset
    always_comb begin
        w_next = r_state;
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        if (r_state == S_READ) begin
            w_rd = reset && !in_empty;
            if (w_rd && r_byte_cnt == 2'(BYTES_PER_SAMPLE-1)) w_next = S_WRITE;
        end else begin
            w_wr = reset && !i_full && !q_full;
            if (w_wr) w_next = S_READ;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_READ;
            r_byte_cnt <= 2'd0;
            r_b        <= '0;
        end else begin
            r_state <= w_next;
            if (w_rd) begin
                r_b[r_byte_cnt] <= in_dout;
                r_byte_cnt      <= r_byte_cnt + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_iq_read.sv
// tb_iq_read: directed checks of byte assembly, quantization, backpressure,
// starvation and mid-sample reset for iq_read.
module tb_iq_read;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_dout = 8'h00;
    logic        in_empty = 1'b1;
    logic        in_rd_en;
    logic [31:0] i_out;
    logic [31:0] q_out;
    logic        i_wr_en;
    logic        q_wr_en;
    logic        i_full = 1'b0;
    logic        q_full = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          t0;
    logic [31:0] hold_i;
    logic [31:0] hold_q;

    iq_read dut (
        .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(in_empty),
        .in_rd_en(in_rd_en), .i_out(i_out), .q_out(q_out), .i_wr_en(i_wr_en),
        .q_wr_en(q_wr_en), .i_full(i_full), .q_full(q_full)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_dout  = b;
        in_empty = 1'b0;
        @(negedge clock);
        chk("pop", {31'd0, in_rd_en}, 32'd1);
        chk("no_wr_in_read", {31'd0, i_wr_en}, 32'd0);
        @(posedge clock);
        #1 in_empty = 1'b1;
    endtask

    task automatic expect_write(input logic [31:0] ei, input logic [31:0] eq);
        @(negedge clock);
        chk("i_wr_en", {31'd0, i_wr_en}, 32'd1);
        chk("q_wr_en", {31'd0, q_wr_en}, 32'd1);
        chk("i_out", i_out, ei);
        chk("q_out", q_out, eq);
        chk("rd_in_write", {31'd0, in_rd_en}, 32'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("wr_one_cycle", {30'd0, i_wr_en, q_wr_en}, 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        in_empty = 1'b0;
        in_dout  = 8'hAA;
        @(negedge clock);
        chk("rst_rd_en", {31'd0, in_rd_en}, 32'd0);
        chk("rst_wr_en", {30'd0, i_wr_en, q_wr_en}, 32'd0);
        chk("rst_i_out", i_out, 32'd0);
        chk("rst_q_out", q_out, 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        in_empty = 1'b1;
        @(posedge clock);
        #1;

        send(8'h01); send(8'h00); send(8'hFF); send(8'hFF);
        expect_write(32'h0000_0400, 32'hFFFF_FC00);

        send(8'h00); send(8'h80); send(8'hFF); send(8'h7F);
        expect_write(32'hFE00_0000, 32'h01FF_FC00);

        t0 = cyc;
        send(8'h01); send(8'h00); send(8'h02); send(8'h00);
        in_dout  = 8'h03;
        in_empty = 1'b0;
        @(negedge clock);
        chk("b2b_wr1", {30'd0, i_wr_en, q_wr_en}, 32'd3);
        chk("b2b_rd1", {31'd0, in_rd_en}, 32'd0);
        chk("b2b_i1", i_out, 32'h0000_0400);
        chk("b2b_q1", q_out, 32'h0000_0800);
        chk("b2b_cyc1", cyc - t0, 32'd4);
        @(posedge clock);
        #1;
        send(8'h03); send(8'h00); send(8'h04); send(8'h00);
        in_empty = 1'b0;
        @(negedge clock);
        chk("b2b_wr2", {30'd0, i_wr_en, q_wr_en}, 32'd3);
        chk("b2b_rd2", {31'd0, in_rd_en}, 32'd0);
        chk("b2b_i2", i_out, 32'h0000_0C00);
        chk("b2b_q2", q_out, 32'h0000_1000);
        chk("b2b_cyc2", cyc - t0, 32'd9);
        @(posedge clock);
        #1 in_empty = 1'b1;

        send(8'h05); send(8'h00); send(8'h06); send(8'h00);
        q_full   = 1'b1;
        in_dout  = 8'h55;
        in_empty = 1'b0;
        hold_i   = 32'h0000_1400;
        hold_q   = 32'h0000_1800;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("bp_no_wr", {30'd0, i_wr_en, q_wr_en}, 32'd0);
            chk("bp_no_rd", {31'd0, in_rd_en}, 32'd0);
            chk("bp_i_hold", i_out, hold_i);
            chk("bp_q_hold", q_out, hold_q);
            @(posedge clock);
            #1;
        end
        q_full = 1'b0;
        @(negedge clock);
        chk("bp_wr", {30'd0, i_wr_en, q_wr_en}, 32'd3);
        chk("bp_i", i_out, hold_i);
        chk("bp_q", q_out, hold_q);
        @(posedge clock);
        #1 in_empty = 1'b1;
        @(negedge clock);
        chk("bp_single_wr", {30'd0, i_wr_en, q_wr_en}, 32'd0);
        @(posedge clock);
        #1;

        send(8'h10); send(8'h00);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("starve_no_rd", {31'd0, in_rd_en}, 32'd0);
            chk("starve_no_wr", {31'd0, i_wr_en}, 32'd0);
            @(posedge clock);
            #1;
        end
        send(8'h20); send(8'h00);
        expect_write(32'h0000_4000, 32'h0000_8000);

        send(8'hAA); send(8'hBB);
        reset    = 1'b0;
        in_empty = 1'b0;
        in_dout  = 8'hCC;
        @(negedge clock);
        chk("mid_rst_rd", {31'd0, in_rd_en}, 32'd0);
        chk("mid_rst_wr", {30'd0, i_wr_en, q_wr_en}, 32'd0);
        chk("mid_rst_i", i_out, 32'd0);
        chk("mid_rst_q", q_out, 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        in_empty = 1'b1;
        send(8'h01); send(8'h00); send(8'h01); send(8'h00);
        expect_write(32'h0000_0400, 32'h0000_0400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/iq_read.md
Name: iq_read

Overview:
Front-end sample assembler that sits directly upstream of the complex channel FIR stage. It pops raw bytes from the radio-input byte FIFO and assembles little-endian 16-bit signed I/Q pairs. Each value is sign-extended and quantized to 32-bit fixed point by shifting left BITS places. It then pushes I and Q together into the two 32-bit FIFOs that feed the channel filter.

Parameters:
DATA_WIDTH, 32, width of quantized I/Q output words
BITS, 10, fixed-point fraction bits; each sample is shifted left by BITS
BYTES_PER_SAMPLE, 4, bytes per I/Q pair (I lo, I hi, Q lo, Q hi); fixed at 4

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_dout  input  8  byte at head of upstream first-word-fall-through FIFO; valid when in_empty=0
in_empty  input  1  upstream byte FIFO empty
in_rd_en  output  1  pop strobe to upstream byte FIFO
i_out  output  DATA_WIDTH  quantized I sample to I FIFO
q_out  output  DATA_WIDTH  quantized Q sample to Q FIFO
i_wr_en  output  1  push strobe to I FIFO
q_wr_en  output  1  push strobe to Q FIFO
i_full  input  1  I FIFO full
q_full  input  1  Q FIFO full

Behaviour:
- reset=0, at any time and asynchronously: state<=S_READ; byte_cnt<=0; byte regs b0..b3<=0. Every output reads 0 while reset is asserted: in_rd_en, i_wr_en, q_wr_en, i_out, q_out.
- Reset during a partial sample discards the collected bytes. No write is generated for them.
- FSM has two states.
- S_READ:
  - in_rd_en = !in_empty (combinational).
  - On a cycle with in_rd_en=1, in_dout is latched into b[byte_cnt] and byte_cnt increments.
  - When byte_cnt==3 and a byte is accepted: byte_cnt<=0 and state<=S_WRITE.
  - in_empty=1 means no pop and no change; gaps of any length are allowed mid-sample.
- S_WRITE:
  - in_rd_en=0.
  - i_wr_en = q_wr_en = !i_full && !q_full (combinational; both strobes are always equal).
  - When the strobes are 1, the pair is pushed and state<=S_READ.
  - Otherwise hold S_WRITE with i_out/q_out stable.
  - I and Q are never written independently.
- Arithmetic:
  - I16 = {b1,b0}, Q16 = {b3,b2}, both two's-complement.
  - i_out = sign_extend_to_DATA_WIDTH(I16) << BITS; q_out likewise.
  - The result occupies at most 16+BITS bits (26 at defaults), so there is no overflow.
  - i_out/q_out are combinational from the byte registers and valid whenever i_wr_en=1.
- Latency and throughput:
  - The pair write occurs in the cycle after the 4th byte pops, if both FIFOs have room.
  - Back-to-back peak is 5 cycles per sample (4 read, 1 write).
- Byte ordering is fixed: the first byte after reset is I lo. There is no resynchronisation mechanism.
- Simultaneous in_empty deassertion and S_WRITE: no read happens until the return to S_READ.

Test Plan:
- Basic conversion: after reset release, push bytes 01 00 FF FF -> one write with i_out=0x00000400, q_out=0xFFFFFC00, i_wr_en=q_wr_en=1 for exactly 1 cycle.
- Extremes: bytes 00 80 FF 7F -> i_out=0xFE000000 (-32768<<10), q_out=0x01FFFC00 (32767<<10).
- Back-to-back: 8 bytes (01 00 02 00 03 00 04 00) with in_empty=0 continuously -> writes (0x400,0x800) then (0xC00,0x1000). The writes land in cycles 5 and 10 counted from the first pop. in_rd_en is low in the write cycles.
- Backpressure: hold q_full=1 for 3 cycles when a sample is ready -> no strobes for 3 cycles, outputs stable and no extra pops. On the 4th cycle a single paired write occurs.
- Starvation: in_empty=1 for 5 cycles between byte 2 and byte 3 of 10 00 20 00 -> still one correct write (i_out=0x4000, q_out=0x8000). in_rd_en stays 0 during the gap.
- Reset mid-sample: pop AA BB, pulse reset low for 1 cycle, then push 01 00 01 00 -> single write i_out=q_out=0x400. AA/BB never appear, and all outputs are 0 during reset.
